point_seq_ctrl: RTL and testbench
=================================

Name: point_seq_ctrl

Overview:
- Sequencing controller for the dataset RAM, which holds one data point per word: features plus y, LENGTH bits per field.
- Arbitrates between a host write/load port and a compute-side streaming read port.
- Issues clear, write and read accesses with the park/target address protocol the RAM needs, because the RAM only acts on an address change.
- Delivers points to the regression datapath over a valid/ready stream.

Parameters:
ADDR_WIDTH, 12, RAM address width
MAX_FEATURES, 15, features per point (excluding y)
LENGTH, 16, bits per field
DATA_WIDTH, LENGTH*(MAX_FEATURES+1), RAM word width
DEPTH, 10, number of stored points; the park address is DEPTH

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
clr  in  1  pulse: clear all RAM words
start  in  1  pulse: stream points 0..num_points-1
num_points  in  ADDR_WIDTH+1  points to stream
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle
wr_addr  in  ADDR_WIDTH  host write address
wr_data  in  DATA_WIDTH  host write word
pt_valid  out  1  point available
pt_ready  in  1  datapath accepts point
pt_data  out  DATA_WIDTH  point word
pt_last  out  1  qualifies final point of pass
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of stream
err_oob  out  1  sticky: out-of-range write dropped
ram_rst, ram_we, ram_oe  out  1 each  RAM controls
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  data to drive on the RAM bus; the top-level tri-states it with ram_we
ram_rdata  in  DATA_WIDTH  RAM bus read-back

Behaviour:
- All outputs are registered.
- Reset values: ram_addr=DEPTH (park), all other outputs 0.
- RST mid-operation aborts immediately: stream dropped, pt_valid=0, err_oob cleared. RAM contents are untouched.
- States and transitions:
  - IDLE: start > clr > wr_valid (fixed priority, checked the same cycle).
  - CLEAR: ram_rst=1 for exactly 1 cycle, then IDLE.
  - WR: ram_we=1, ram_wdata=wr_data, ram_addr=wr_addr, all in the same cycle. Then PARK.
  - RD: ram_we=0, ram_oe=1, ram_addr=rd_ptr. Next edge captures ram_rdata into pt_data and sets pt_valid; then PARK_RD.
  - PARK_RD: ram_addr=DEPTH, oe=0. Stay while pt_valid && !pt_ready.
    - On handshake: if rd_ptr+1 < count, rd_ptr++ and go RD.
    - Otherwise go IDLE and pulse done.
  - PARK: ram_addr=DEPTH for 1 cycle, then IDLE.
- Every access is preceded and followed by the park address, so repeated same-address accesses still retrigger the RAM.
- wr_ready is a 1-cycle pulse in the IDLE->WR transition cycle. A write costs 2 cycles (WR + PARK). wr_ready=0 whenever not IDLE.
- wr_addr >= DEPTH: the request is acknowledged, but no ram_we is issued (ram_addr stays parked), and err_oob is set. err_oob is cleared only by clr or RST.
- start latches count=min(num_points, DEPTH) and sets rd_ptr=0.
  - count=0: no RAM access; done pulses the next cycle and the block returns to IDLE.
- start, clr and wr_valid are ignored while busy. pt_data stays stable while pt_valid && !pt_ready.
- pt_last=1 together with the pt_valid of point count-1.
- Latency: start to first pt_valid is 3 cycles (latch, RD, capture). Peak throughput is 1 point per 2 cycles.
- done and pt_valid never both drop in the same cycle: done pulses in the cycle after the final handshake.

Optional Feature:
POINT_SEQ_EPOCH_EN:
- Adds an input epochs [7:0], latched at start.
- After the last point, rd_ptr wraps to 0 and streaming repeats for epochs passes in total; epochs=0 is treated as 1.
- pt_last marks the last point of every pass; done pulses only after the final pass.
- Without the macro, there is no epochs port and exactly one pass runs.

Test Plan:
- RST, clr -> ram_rst high exactly 1 cycle; busy 1 cycle; ram_addr=DEPTH after.
- Write addr 3 = 0xA5.., then addr 3 = 0x5A.. back-to-back -> two WR cycles each separated by ram_addr=10 (park); RAM word 3 = 0x5A..
- Load points 0..9, start num_points=4, pt_ready=1 -> pt_data = words 0,1,2,3 every 2 cycles, first at 3 cycles after start; pt_last on word 3; done 1 cycle later.
- Same stream, pt_ready held low 5 cycles on point 1 -> pt_data stable, no RAM access, sequence resumes unchanged; num_points=20 -> clamped to 10 points.
- wr_addr=12 -> wr_ready pulse, no ram_we, err_oob=1 until clr; start num_points=0 -> done next cycle, no ram_oe.
- RST asserted mid-stream at point 2 -> next cycle pt_valid=0, busy=0, ram_addr=10; new start restarts from word 0.

Source files
------------

// File: rtl/point_seq_ctrl.sv
// Dataset RAM sequencer: host writes, clears and streamed point reads, with every access framed by the park address.
// Optional multi-pass streaming is enabled by defining POINT_SEQ_EPOCH_EN (adds the epochs input).
module point_seq_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
  parameter int DEPTH        = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_points,
`ifdef POINT_SEQ_EPOCH_EN
  input  logic [7:0]            epochs,
`endif
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  pt_valid,
  input  logic                  pt_ready,
  output logic [DATA_WIDTH-1:0] pt_data,
  output logic                  pt_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_oob,
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] PARK_ADDR = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_W     = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_WR, S_PARK, S_RD, S_PARK_RD
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH:0]   count, count_n, clamp, rd_nxt_w;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_n, ram_addr_n;
  logic [DATA_WIDTH-1:0] pt_data_n, ram_wdata_n;
  logic                  wr_ready_n, pt_valid_n, pt_last_n, busy_n, done_n, err_oob_n;
  logic                  ram_rst_n, ram_we_n, ram_oe_n;
`ifdef POINT_SEQ_EPOCH_EN
  logic [7:0]            epochs_q, epochs_q_n, pass_q, pass_q_n;
`endif

  always_comb begin
    clamp    = (num_points > DEPTH_W) ? DEPTH_W : num_points;
    rd_nxt_w = {1'b0, rd_ptr} + ONE_W;
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    rd_ptr_n    = rd_ptr;
    pt_data_n   = pt_data;
    pt_valid_n  = pt_valid;
    pt_last_n   = pt_last;
    err_oob_n   = err_oob;
    ram_wdata_n = ram_wdata;
    ram_addr_n  = PARK_ADDR;
    wr_ready_n  = 1'b0;
    done_n      = 1'b0;
    ram_rst_n   = 1'b0;
    ram_we_n    = 1'b0;
    ram_oe_n    = 1'b0;
`ifdef POINT_SEQ_EPOCH_EN
    epochs_q_n  = epochs_q;
    pass_q_n    = pass_q;
`endif
    unique case (state)
      S_IDLE: begin
        if (start) begin
          count_n  = clamp;
          rd_ptr_n = '0;
`ifdef POINT_SEQ_EPOCH_EN
          epochs_q_n = (epochs == 8'd0) ? 8'd1 : epochs;
          pass_q_n   = '0;
`endif
          // An empty stream never touches the RAM; done is reported straight away.
          if (clamp == '0) done_n  = 1'b1;
          else             state_n = S_LOAD;
        end else if (clr) begin
          state_n   = S_CLEAR;
          ram_rst_n = 1'b1;
          err_oob_n = 1'b0;
        end else if (wr_valid) begin
          state_n    = S_WR;
          wr_ready_n = 1'b1;
          if (wr_addr < PARK_ADDR) begin
            ram_we_n    = 1'b1;
            ram_addr_n  = wr_addr;
            ram_wdata_n = wr_data;
          end else begin
            err_oob_n = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_n    = S_RD;
        ram_oe_n   = 1'b1;
        ram_addr_n = rd_ptr;
      end
      S_CLEAR: state_n = S_IDLE;
      S_WR:    state_n = S_PARK;
      S_PARK:  state_n = S_IDLE;
      S_RD: begin
        state_n    = S_PARK_RD;
        pt_valid_n = 1'b1;
        pt_data_n  = ram_rdata;
        pt_last_n  = (rd_nxt_w == count);
      end
      S_PARK_RD: begin
        if (pt_ready) begin
          pt_valid_n = 1'b0;
          pt_last_n  = 1'b0;
          if (rd_nxt_w < count) begin
            rd_ptr_n   = rd_nxt_w[ADDR_WIDTH-1:0];
            state_n    = S_RD;
            ram_oe_n   = 1'b1;
            ram_addr_n = rd_nxt_w[ADDR_WIDTH-1:0];
`ifdef POINT_SEQ_EPOCH_EN
          end else if ((pass_q + 8'd1) < epochs_q) begin
            pass_q_n   = pass_q + 8'd1;
            rd_ptr_n   = '0;
            state_n    = S_RD;
            ram_oe_n   = 1'b1;
            ram_addr_n = '0;
`endif
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ready  <= 1'b0;
      pt_valid  <= 1'b0;
      pt_data   <= '0;
      pt_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_oob   <= 1'b0;
      ram_rst   <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= PARK_ADDR;
      ram_wdata <= '0;
`ifdef POINT_SEQ_EPOCH_EN
      epochs_q  <= 8'd1;
      pass_q    <= '0;
`endif
    end else begin
      state     <= state_n;
      count     <= count_n;
      rd_ptr    <= rd_ptr_n;
      wr_ready  <= wr_ready_n;
      pt_valid  <= pt_valid_n;
      pt_data   <= pt_data_n;
      pt_last   <= pt_last_n;
      busy      <= busy_n;
      done      <= done_n;
      err_oob   <= err_oob_n;
      ram_rst   <= ram_rst_n;
      ram_we    <= ram_we_n;
      ram_oe    <= ram_oe_n;
      ram_addr  <= ram_addr_n;
      ram_wdata <= ram_wdata_n;
`ifdef POINT_SEQ_EPOCH_EN
      epochs_q  <= epochs_q_n;
      pass_q    <= pass_q_n;
`endif
    end
  end

endmodule

// File: tb/tb_point_seq_ctrl.sv
// Randomised bench for point_seq_ctrl: behavioural RAM plus a point-list reference model of the stream.
module tb_point_seq_ctrl;
  localparam int AW    = 12;
  localparam int DW    = 256;
  localparam int DEPTH = 10;
  localparam logic [AW-1:0] PARK = AW'(DEPTH);

  logic          CLK = 1'b0, RST = 1'b1, clr = 1'b0, start = 1'b0;
  logic          wr_valid = 1'b0, pt_ready = 1'b0;
  logic [AW:0]   num_points = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
`ifdef POINT_SEQ_EPOCH_EN
  logic [7:0]    epochs = 8'd1;
`endif
  logic          wr_ready, pt_valid, pt_last, busy, done, err_oob, ram_rst, ram_we, ram_oe;
  logic [DW-1:0] pt_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_err = 1'b0;
  int unsigned   n_tests = 0, n_fail = 0, oe_cnt = 0, we_cnt = 0;
  logic [AW-1:0] prev_addr = PARK;
  logic          prev_acc = 1'b0;

  always #5 CLK = ~CLK;

  point_seq_ctrl #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .start(start), .num_points(num_points),
`ifdef POINT_SEQ_EPOCH_EN
    .epochs(epochs),
`endif
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .busy(busy), .done(done), .err_oob(err_oob),
    .ram_rst(ram_rst), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural dataset RAM
  always @(posedge CLK) begin
    if (ram_rst) for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
    else if (ram_we && ram_addr < PARK) ram[ram_addr[3:0]] <= ram_wdata;
  end
  assign ram_rdata = (ram_oe && ram_addr < PARK) ? ram[ram_addr[3:0]] : '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every RAM access must sit between park-address cycles.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ram_we || ram_oe) begin
        chk("park_pre", prev_addr, PARK);
        if (ram_oe) oe_cnt++;
        if (ram_we) we_cnt++;
      end
      if (prev_acc) chk("park_post", ram_addr, PARK);
    end
    prev_addr = ram_addr;
    prev_acc  = ram_we | ram_oe;
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[32*k +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_clr();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_ram_rst", ram_rst, 1'b1);
    chk("clr_busy", busy, 1'b1);
    tick();
    chk("clr_ram_rst_end", ram_rst, 1'b0);
    chk("clr_busy_end", busy, 1'b0);
    chk("clr_park", ram_addr, PARK);
    chk("clr_err", err_oob, 1'b0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_err = 1'b0;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit seen = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (wr_ready === 1'b1) seen = 1;
    end
    wr_valid = 1'b0;
    chk("wr_ready", seen, 1'b1);
    if (a < PARK) ref_mem[a[3:0]] = d;
    else ref_err = 1'b1;
    chk("wr_we", ram_we, a < PARK);
    chk("wr_addr", ram_addr, (a < PARK) ? a : PARK);
    if (a < PARK) chk("wr_data", ram_wdata, d);
    chk("wr_err", err_oob, ref_err);
    tick();
    chk("wr_ready_pulse", wr_ready, 1'b0);
    chk("wr_park", ram_addr, PARK);
    tick();
    chk("wr_idle", busy, 1'b0);
  endtask

  task automatic run_stream(input int unsigned n, input int mode);
    logic [DW-1:0] exp_q[$];
    bit            last_q[$];
    logic [DW-1:0] held = '0;
    int unsigned   cnt, passes, total, hs = 0, stall = 0, cyc = 1, done_cyc = 0, last_hs = 0, oe0;
    bit            fin = 0, first = 0, hold = 0;
    cnt    = (n > DEPTH) ? DEPTH : n;
    passes = 1;
`ifdef POINT_SEQ_EPOCH_EN
    passes = (epochs == 8'd0) ? 1 : epochs;
`endif
    for (int unsigned p = 0; p < passes; p++)
      for (int unsigned i = 0; i < cnt; i++) begin
        exp_q.push_back(ref_mem[i]);
        last_q.push_back(i == cnt - 1);
      end
    total = exp_q.size();
    oe0 = oe_cnt;
    start = 1'b1; num_points = (AW + 1)'(n);
    tick();
    start = 1'b0;
    if (total == 0) begin
      chk("empty_done", done, 1'b1);
      chk("empty_busy", busy, 1'b0);
      tick();
      chk("empty_done_pulse", done, 1'b0);
      tick();
      chk("empty_no_oe", oe_cnt - oe0, 0);
      return;
    end
    while (!fin && cyc < 400) begin
      if (mode == 2 && pt_valid && hs == 1 && stall < 5) begin pt_ready = 1'b0; stall++; end
      else if (mode == 1) pt_ready = 1'($urandom_range(0, 1));
      else pt_ready = 1'b1;
      if (hold) begin
        chk("hold_valid", pt_valid, 1'b1);
        chk("hold_data", pt_data, held);
      end
      if (pt_valid && !first) begin first = 1; chk("first_latency", cyc, 3); end
      if (cyc == done_cyc) begin
        chk("done", done, 1'b1);
        chk("valid_after_done", pt_valid, 1'b0);
        fin = 1;
      end else if (done) chk("done_early", done, 1'b0);
      if (!fin && pt_valid && pt_ready && exp_q.size() > 0) begin
        chk("pt_data", pt_data, exp_q.pop_front());
        chk("pt_last", pt_last, last_q.pop_front());
        if (mode == 0 && hs > 0) chk("rate", cyc - last_hs, 2);
        last_hs = cyc;
        hs++;
        if (exp_q.size() == 0) done_cyc = cyc + 1;
      end
      hold = pt_valid && !pt_ready;
      held = pt_data;
      tick();
      cyc++;
    end
    pt_ready = 1'b0;
    if (!fin) chk("stream_timeout", fin, 1'b1);
    chk("hs_count", hs, total);
    chk("oe_count", oe_cnt - oe0, total);
    chk("busy_end", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned we0, hs;
    RST = 1'b1; tick(); tick();
    chk("rst_addr", ram_addr, PARK);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", pt_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_oob, 1'b0);
    chk("rst_ctrl", {ram_rst, ram_we, ram_oe, wr_ready, pt_last}, 5'b0);
    RST = 1'b0; tick();

    do_clr();
    we0 = we_cnt;
    host_write(12'd3, {32{8'hA5}});
    host_write(12'd3, {32{8'h5A}});
    tick();
    chk("ram_word3", ram[3], {32{8'h5A}});
    chk("we_count", we_cnt - we0, 2);

    for (int i = 0; i < DEPTH; i++) host_write(AW'(i), rand_word());
    run_stream(4, 0);
    run_stream(4, 2);
    run_stream(20, 0);

    host_write(12'd12, rand_word());
    run_stream(0, 0);
    chk("err_sticky", err_oob, 1'b1);
    do_clr();
    run_stream(3, 0);

    for (int i = 0; i < DEPTH; i++) host_write(AW'(i), rand_word());
    for (int r = 0; r < 6; r++) begin
`ifdef POINT_SEQ_EPOCH_EN
      epochs = 8'($urandom_range(0, 2));
`endif
      run_stream($urandom_range(0, 15), 1);
    end
`ifdef POINT_SEQ_EPOCH_EN
    epochs = 8'd1;
`endif

    host_write(12'd200, rand_word());
    start = 1'b1; num_points = 13'd10; pt_ready = 1'b1;
    tick();
    start = 1'b0;
    hs = 0;
    for (int i = 0; i < 40 && !(pt_valid && hs == 2); i++) begin
      if (pt_valid) hs++;
      tick();
    end
    chk("abort_at_pt2", pt_data, ref_mem[2]);
    RST = 1'b1; tick();
    chk("abort_valid", pt_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", ram_addr, PARK);
    chk("abort_err", err_oob, 1'b0);
    RST = 1'b0; pt_ready = 1'b0; ref_err = 1'b0;
    tick();
    run_stream(5, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
